// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file indices, widths and writeback types
package riscv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int XLEN      = 64;

    typedef enum logic {
        INT = 1'b0,
        FLT = 1'b1
    } reg_bank_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        reg_bank_t            reg_type;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter owning its rotating pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // First pass covers indices at or above the pointer, second pass wraps to the bottom.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                gidx   = PW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                gidx   = PW'(i);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// rtl/wb_scheduler.sv - writeback arbitration, register-file write stage and pending-write scoreboard
module wb_scheduler
    import riscv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*REG_IDX_W-1:0] req_rd,
    input  logic [N_REQ-1:0]           req_type,
    input  logic [N_REQ*XLEN-1:0]      req_data,
    output logic [REG_IDX_W-1:0]       rd_wb,
    output logic                       reg_type_wb,
    output logic [XLEN-1:0]            op_wb,
    output logic                       we_rd_wb,
    input  logic                       issue_valid,
    input  logic [REG_IDX_W-1:0]       issue_rd,
    input  logic                       issue_type,
    input  logic [REG_IDX_W-1:0]       rs1_dec,
    input  logic [REG_IDX_W-1:0]       rs2_dec,
    input  logic [REG_IDX_W-1:0]       rs3_dec,
    input  logic [2:0]                 rs_used,
    input  logic                       reg_type_dec,
    input  logic [REG_IDX_W-1:0]       rd_dec,
    input  logic                       rd_used,
    input  logic                       rd_type_dec,
    output logic                       stall_dec
);

    logic [N_REQ-1:0]     gnt;
    logic [REG_IDX_W-1:0] sel_rd;
    logic                 sel_type;
    logic [XLEN-1:0]      sel_data;

    logic [1:0][NUM_REGS-1:0] busy;
    logic [1:0][NUM_REGS-1:0] busy_nxt;
    logic                     raw_hit;
    logic                     waw_hit;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (req_valid),
        .gnt     (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_rd   = '0;
        sel_type = 1'b0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[REG_IDX_W*i +: REG_IDX_W];
                sel_type = req_type[i];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // Payload holds its last value on idle cycles; only the write enable drops.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_wb       <= '0;
            reg_type_wb <= 1'b0;
            op_wb       <= '0;
            we_rd_wb    <= 1'b0;
        end else begin
            we_rd_wb <= |gnt;
            if (|gnt) begin
                rd_wb       <= sel_rd;
                reg_type_wb <= sel_type;
                op_wb       <= sel_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue of the retiring register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (we_rd_wb && (rd_wb != '0)) begin
            busy_nxt[reg_type_wb][rd_wb] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_type][issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign raw_hit = (rs_used[0] && busy[reg_type_dec][rs1_dec]) ||
                     (rs_used[1] && busy[reg_type_dec][rs2_dec]) ||
                     (rs_used[2] && busy[reg_type_dec][rs3_dec]);
    assign waw_hit = rd_used && (rd_dec != '0) && busy[rd_type_dec][rd_dec];
    assign stall_dec = raw_hit || waw_hit;

endmodule

// File: tb/tb_wb_scheduler.sv
// tb/tb_wb_scheduler.sv - directed self-checking bench for wb_scheduler
module tb_wb_scheduler;

    logic         clk = 1'b0;
    logic         n_reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_rd;
    logic [3:0]   req_type;
    logic [255:0] req_data;
    logic [4:0]   rd_wb;
    logic         reg_type_wb;
    logic [63:0]  op_wb;
    logic         we_rd_wb;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_type;
    logic [4:0]   rs1_dec, rs2_dec, rs3_dec;
    logic [2:0]   rs_used;
    logic         reg_type_dec;
    logic [4:0]   rd_dec;
    logic         rd_used;
    logic         rd_type_dec;
    logic         stall_dec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_scheduler #(.N_REQ(4), .XLEN(64)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_type     (req_type),
        .req_data     (req_data),
        .rd_wb        (rd_wb),
        .reg_type_wb  (reg_type_wb),
        .op_wb        (op_wb),
        .we_rd_wb     (we_rd_wb),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_type   (issue_type),
        .rs1_dec      (rs1_dec),
        .rs2_dec      (rs2_dec),
        .rs3_dec      (rs3_dec),
        .rs_used      (rs_used),
        .reg_type_dec (reg_type_dec),
        .rd_dec       (rd_dec),
        .rd_used      (rd_used),
        .rd_type_dec  (rd_type_dec),
        .stall_dec    (stall_dec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic t, input logic [63:0] d);
        req_rd[5*i +: 5]    = rd;
        req_type[i]         = t;
        req_data[64*i +: 64] = d;
    endtask

    task automatic query(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                         input logic [2:0] used, input logic bank,
                         input logic [4:0] rd, input logic rdu, input logic rdt);
        rs1_dec = r1; rs2_dec = r2; rs3_dec = r3; rs_used = used; reg_type_dec = bank;
        rd_dec = rd; rd_used = rdu; rd_type_dec = rdt;
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        req_valid = '0; req_rd = '0; req_type = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_type = 1'b0;
        query(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++;
        if (we_rd_wb !== 1'b0 || rd_wb !== 5'd0 || reg_type_wb !== 1'b0 || op_wb !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b rd=%0d type=%b op=%h expected all zero", we_rd_wb, rd_wb, reg_type_wb, op_wb);
        end
        checks++;
        if (req_ready !== 4'b0000 || stall_dec !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_stall got ready=%b stall=%b expected 0000 0", req_ready, stall_dec);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 5'd5, 1'b0, 64'hDEAD);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b expected 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (we_rd_wb !== 1'b1 || rd_wb !== 5'd5 || reg_type_wb !== 1'b0 || op_wb !== 64'hDEAD) begin
            errors++;
            $display("FAIL single_write got we=%b rd=%0d type=%b op=%h expected 1 5 0 dead", we_rd_wb, rd_wb, reg_type_wb, op_wb);
        end
        step();
        checks++;
        if (we_rd_wb !== 1'b0 || rd_wb !== 5'd5 || op_wb !== 64'hDEAD) begin
            errors++;
            $display("FAIL single_idle_hold got we=%b rd=%0d op=%h expected 0 5 dead", we_rd_wb, rd_wb, op_wb);
        end
    endtask

    task automatic test_fairness();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_ready;
        n_reset = 1'b0;
        #1;
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 5'd0, 1'b0, 64'h100 + 64'(i));
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_ready = 4'b0001 << exp_g[c];
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL fair_grant cycle %0d got %b expected %b", c, req_ready, exp_ready);
            end
            if (c > 0) begin
                checks++;
                if (we_rd_wb !== 1'b1 || op_wb !== 64'h100 + 64'(exp_g[c-1])) begin
                    errors++;
                    $display("FAIL fair_write cycle %0d got we=%b op=%h expected 1 %h", c, we_rd_wb, op_wb, 64'h100 + 64'(exp_g[c-1]));
                end
            end
            step();
        end
        req_valid = 4'b0000;
        checks++;
        if (we_rd_wb !== 1'b1 || op_wb !== 64'h100) begin
            errors++;
            $display("FAIL fair_last_write got we=%b op=%h expected 1 100", we_rd_wb, op_wb);
        end
    endtask

    task automatic test_raw();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_type = 1'b1;
        step();
        issue_valid = 1'b0;
        query(5'd7, 5'd0, 5'd0, 3'b001, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL raw_f7 got %b expected 1", stall_dec); end
        query(5'd7, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL raw_x7 got %b expected 0", stall_dec); end
        query(5'd0, 5'd0, 5'd7, 3'b100, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL raw_rs3_f7 got %b expected 1", stall_dec); end
        query(5'd0, 5'd0, 5'd7, 3'b011, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL raw_rs3_unused got %b expected 0", stall_dec); end
        query(5'd7, 5'd0, 5'd0, 3'b001, 1'b1, 5'd0, 1'b0, 1'b0);
        set_req(2, 5'd7, 1'b1, 64'hF7F7);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || stall_dec !== 1'b1) begin
            errors++;
            $display("FAIL raw_grant got ready=%b stall=%b expected 0100 1", req_ready, stall_dec);
        end
        step();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (we_rd_wb !== 1'b1 || rd_wb !== 5'd7 || reg_type_wb !== 1'b1 || stall_dec !== 1'b1) begin
            errors++;
            $display("FAIL raw_wb_cycle got we=%b rd=%0d type=%b stall=%b expected 1 7 1 1", we_rd_wb, rd_wb, reg_type_wb, stall_dec);
        end
        step();
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL raw_after_wb got %b expected 0", stall_dec); end
    endtask

    task automatic test_collision();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_type = 1'b0;
        step();
        issue_valid = 1'b0;
        set_req(1, 5'd9, 1'b0, 64'h99);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_type = 1'b0;
        #1;
        checks++;
        if (we_rd_wb !== 1'b1 || rd_wb !== 5'd9) begin
            errors++;
            $display("FAIL coll_wb got we=%b rd=%0d expected 1 9", we_rd_wb, rd_wb);
        end
        step();
        issue_valid = 1'b0;
        query(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd9, 1'b1, 1'b0);
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL coll_waw_x9 got %b expected 1", stall_dec); end
        query(5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd9, 1'b1, 1'b1);
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL coll_waw_f9 got %b expected 0", stall_dec); end
    endtask

    task automatic test_rd0();
        issue_valid = 1'b1; issue_rd = 5'd0; issue_type = 1'b0;
        step();
        issue_type = 1'b1;
        set_req(0, 5'd0, 1'b1, 64'hA0);
        req_valid = 4'b0001;
        step();
        issue_valid = 1'b0;
        set_req(0, 5'd0, 1'b0, 64'hB0);
        checks++;
        if (we_rd_wb !== 1'b1 || rd_wb !== 5'd0 || reg_type_wb !== 1'b1 || op_wb !== 64'hA0) begin
            errors++;
            $display("FAIL rd0_flt_write got we=%b rd=%0d type=%b op=%h expected 1 0 1 a0", we_rd_wb, rd_wb, reg_type_wb, op_wb);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (we_rd_wb !== 1'b1 || reg_type_wb !== 1'b0 || op_wb !== 64'hB0) begin
            errors++;
            $display("FAIL rd0_int_write got we=%b type=%b op=%h expected 1 0 b0", we_rd_wb, reg_type_wb, op_wb);
        end
        step();
        for (int b = 0; b < 2; b++) begin
            query(5'd0, 5'd0, 5'd0, 3'b111, b[0], 5'd0, 1'b1, b[0]);
            checks++;
            if (stall_dec !== 1'b0) begin errors++; $display("FAIL rd0_busy bank %0d got %b expected 0", b, stall_dec); end
        end
        query(5'd9, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL rd0_x9_kept got %b expected 1", stall_dec); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_rd = 5'd3; issue_type = 1'b1;
        set_req(2, 5'd12, 1'b1, 64'hC2);
        req_valid = 4'b0100;
        step();
        issue_valid = 1'b0;
        set_req(1, 5'd0, 1'b0, 64'hC1);
        set_req(3, 5'd0, 1'b0, 64'hC3);
        req_valid = 4'b1110;
        query(5'd3, 5'd0, 5'd0, 3'b001, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++;
        if (req_ready !== 4'b1000 || we_rd_wb !== 1'b1 || op_wb !== 64'hC2 || stall_dec !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got ready=%b we=%b op=%h stall=%b expected 1000 1 c2 1", req_ready, we_rd_wb, op_wb, stall_dec);
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if (we_rd_wb !== 1'b0 || rd_wb !== 5'd0 || reg_type_wb !== 1'b0 || op_wb !== 64'd0 || stall_dec !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out got we=%b rd=%0d type=%b op=%h stall=%b expected all zero", we_rd_wb, rd_wb, reg_type_wb, op_wb, stall_dec);
        end
        query(5'd9, 5'd0, 5'd0, 3'b001, 1'b0, 5'd9, 1'b1, 1'b0);
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL mid_reset_x9 got %b expected 0", stall_dec); end
        @(posedge clk);
        #3;
        n_reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL post_reset_grant got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++;
        if (we_rd_wb !== 1'b1 || op_wb !== 64'hC1) begin
            errors++;
            $display("FAIL post_reset_write got we=%b op=%h expected 1 c1", we_rd_wb, op_wb);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_raw();
        test_collision();
        test_rd0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
